// File: rtl/game_pkg.sv
// Shared constants and types for the game input path: key indices, default
// debounce/repeat timing and the per-key channel state encoding.
package game_pkg;

   localparam int KEY_START = 3;
   localparam int KEY_RESET = 0;

   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_REPEAT_DELAY    = 25_000_000;
   localparam int DEF_REPEAT_PERIOD   = 5_000_000;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } key_state_t;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int count_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_press_conditioner_if.sv
// Key-side bundle of key_press_conditioner: raw keys and enable in, debounced
// levels and press/release strobes out.
interface key_press_conditioner_if #(
   parameter int NUM_KEYS = 4
);

   logic                enable;
   logic [NUM_KEYS-1:0] key_n;
   logic [NUM_KEYS-1:0] key_held;
   logic [NUM_KEYS-1:0] press_pulse;
   logic [NUM_KEYS-1:0] release_pulse;

   modport master (
      output enable,
      output key_n,
      input  key_held,
      input  press_pulse,
      input  release_pulse
   );

   modport slave (
      input  enable,
      input  key_n,
      output key_held,
      output press_pulse,
      output release_pulse
   );

endinterface

// File: rtl/key_debounce_cell.sv
// One key channel: 2-flop synchronizer, debounce FSM and registered strobes.
// Optional auto-repeat while held is built only when KEY_REPEAT_EN is defined.
module key_debounce_cell
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic held,
   output logic press_strobe,
   output logic release_strobe
);

   localparam int               CNT_W    = count_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             pressed;
   key_state_t       state;
   logic [CNT_W-1:0] cnt;

`ifdef KEY_REPEAT_EN
   localparam int RPT_W = count_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD);
   localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_phase;
`endif

   // Synchronizer flops rest at the released (high) pin level.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= key_n;
         sync_b <= sync_a;
      end
   end

   assign pressed = ~sync_b;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         cnt            <= '0;
         held           <= 1'b0;
         press_strobe   <= 1'b0;
         release_strobe <= 1'b0;
`ifdef KEY_REPEAT_EN
         rpt_cnt        <= '0;
         rpt_phase      <= 1'b0;
`endif
      end else begin
         press_strobe   <= 1'b0;
         release_strobe <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pressed) begin
                  cnt   <= '0;
                  state <= PRESS_WAIT;
               end
            end
            PRESS_WAIT: begin
               if (!pressed) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state        <= HELD;
                  held         <= 1'b1;
                  press_strobe <= 1'b1;
`ifdef KEY_REPEAT_EN
                  rpt_cnt      <= '0;
                  rpt_phase    <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               // Release detection wins over a repeat falling due in the same cycle.
               if (!pressed) begin
                  cnt   <= '0;
                  state <= RELEASE_WAIT;
               end
`ifdef KEY_REPEAT_EN
               else if (rpt_cnt == (rpt_phase ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                  press_strobe <= 1'b1;
                  rpt_cnt      <= '0;
                  rpt_phase    <= 1'b1;
               end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
               end
`endif
            end
            RELEASE_WAIT: begin
               if (pressed) begin
                  cnt   <= '0;
                  state <= HELD;
               end else if (cnt == CNT_LAST) begin
                  state          <= IDLE;
                  held           <= 1'b0;
                  release_strobe <= 1'b1;
`ifdef KEY_REPEAT_EN
                  rpt_cnt        <= '0;
                  rpt_phase      <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_press_conditioner.sv
// Debounces NUM_KEYS active-low push-buttons into clean levels and one-cycle
// press/release strobes; KEY_REPEAT_EN adds auto-repeat press strobes while held.
module key_press_conditioner
   import game_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                     clock,
   input  logic                     resetn,
   key_press_conditioner_if.slave   bus
);

   logic [NUM_KEYS-1:0] held;
   logic [NUM_KEYS-1:0] press_strobe;
   logic [NUM_KEYS-1:0] release_strobe;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("key_press_conditioner: invalid timing parameters");
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_cell (
         .clock          (clock),
         .resetn         (resetn),
         .key_n          (bus.key_n[i]),
         .held           (held[i]),
         .press_strobe   (press_strobe[i]),
         .release_strobe (release_strobe[i])
      );
   end

   // Gating is combinational so a low enable suppresses a strobe in its own cycle.
   assign bus.key_held      = held;
   assign bus.press_pulse   = press_strobe & {NUM_KEYS{bus.enable}};
   assign bus.release_pulse = release_strobe & {NUM_KEYS{bus.enable}};

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3; repeat section follows KEY_REPEAT_EN.
module tb_key_press_conditioner;
   import game_pkg::*;

   localparam int NK = 4;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;
   // Drive happens just after edge t0; first sampling edge is cycle 0 = t0+1,
   // pulse appears in cycle 2+DB, i.e. bench cycle count t0 + DB + 3.
   localparam int LAT = DB + 3;
   localparam int KS = KEY_START;
   localparam int KR = KEY_RESET;

   logic clock = 1'b0;
   logic resetn;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   t0;

   int press_cnt[NK];
   int release_cnt[NK];
   int press_cyc[NK];
   int release_cyc[NK];
   int dual_cnt = 0;
   int hist[8];
   int hist_n = 0;

   key_press_conditioner_if #(.NUM_KEYS(NK)) bus ();

   key_press_conditioner #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      for (int k = 0; k < NK; k++) begin
         if (bus.press_pulse[k] === 1'b1) begin
            press_cnt[k] = press_cnt[k] + 1;
            press_cyc[k] = cyc;
            if (k == 2 && hist_n < 8) begin
               hist[hist_n] = cyc;
               hist_n = hist_n + 1;
            end
         end
         if (bus.release_pulse[k] === 1'b1) begin
            release_cnt[k] = release_cnt[k] + 1;
            release_cyc[k] = cyc;
         end
         if (bus.press_pulse[k] === 1'b1 && bus.release_pulse[k] === 1'b1)
            dual_cnt = dual_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic clear_counts();
      for (int k = 0; k < NK; k++) begin
         press_cnt[k]   = 0;
         release_cnt[k] = 0;
         press_cyc[k]   = -1;
         release_cyc[k] = -1;
      end
      hist_n = 0;
   endtask

   initial begin
      clear_counts();
      resetn     = 1'b0;
      bus.enable = 1'b1;
      bus.key_n  = '1;
      wait_cycles(3);
      check("rst_held", bus.key_held, 0);
      check("rst_press", bus.press_pulse, 0);
      check("rst_release", bus.release_pulse, 0);
      resetn = 1'b1;
      wait_cycles(3);

      // Clean press on the start key
      clear_counts();
      bus.key_n[KS] = 1'b0;
      t0 = cyc;
      wait_cycles(LAT - 1);
      check("press_held_early", bus.key_held[KS], 0);
      check("press_pulse_early", bus.press_pulse[KS], 0);
      wait_cycles(1);
      check("press_pulse", bus.press_pulse[KS], 1);
      check("press_held", bus.key_held[KS], 1);
      wait_cycles(1);
      check("press_width", bus.press_pulse[KS], 0);
      wait_cycles(7);
      check("press_count", press_cnt[KS], 1);
      check("press_time", press_cyc[KS], t0 + LAT);

      // Clean release
      clear_counts();
      bus.key_n[KS] = 1'b1;
      t0 = cyc;
      wait_cycles(15);
      check("rel_count", release_cnt[KS], 1);
      check("rel_time", release_cyc[KS], t0 + LAT);
      check("rel_held", bus.key_held[KS], 0);
      check("rel_no_press", press_cnt[KS], 0);

      // Bounce 0,1,0,1 then settle low
      clear_counts();
      bus.key_n[KS] = 1'b0; wait_cycles(1);
      bus.key_n[KS] = 1'b1; wait_cycles(1);
      bus.key_n[KS] = 1'b0; wait_cycles(1);
      bus.key_n[KS] = 1'b1; wait_cycles(1);
      bus.key_n[KS] = 1'b0;
      t0 = cyc;
      wait_cycles(15);
      check("bounce_count", press_cnt[KS], 1);
      check("bounce_time", press_cyc[KS], t0 + LAT);

      // 3-cycle release glitch while held
      clear_counts();
      bus.key_n[KS] = 1'b1; wait_cycles(3);
      bus.key_n[KS] = 1'b0; wait_cycles(10);
      check("glitch_no_release", release_cnt[KS], 0);
      check("glitch_held", bus.key_held[KS], 1);
      bus.key_n[KS] = 1'b1;
      wait_cycles(15);
      check("glitch_then_release", release_cnt[KS], 1);

      // Press shorter than the debounce window
      clear_counts();
      bus.key_n[KS] = 1'b0; wait_cycles(3);
      bus.key_n[KS] = 1'b1; wait_cycles(12);
      check("short_no_press", press_cnt[KS], 0);
      check("short_no_release", release_cnt[KS], 0);
      check("short_held", bus.key_held[KS], 0);

      // Enable low across acceptance, raised afterwards
      clear_counts();
      bus.enable    = 1'b0;
      bus.key_n[KS] = 1'b0;
      t0 = cyc;
      wait_cycles(LAT + 2);
      check("gate_held", bus.key_held[KS], 1);
      bus.enable = 1'b1;
      wait_cycles(5);
      check("gate_no_press", press_cnt[KS], 0);
      bus.key_n[KS] = 1'b1;
      wait_cycles(15);
      check("gate_release", release_cnt[KS], 1);

      // Two keys pressed together
      clear_counts();
      bus.key_n[KR] = 1'b0;
      bus.key_n[KS] = 1'b0;
      t0 = cyc;
      wait_cycles(15);
      check("multi_cnt0", press_cnt[KR], 1);
      check("multi_cnt3", press_cnt[KS], 1);
      check("multi_time3", press_cyc[KS], t0 + LAT);
      check("multi_same", press_cyc[KR], press_cyc[KS]);
      check("multi_held", bus.key_held, 4'b1001);

      // Reset while key 1 is mid-debounce, keys held through reset release
      bus.key_n[1] = 1'b0;
      wait_cycles(4);
      resetn = 1'b0;
      #1;
      check("midrst_held", bus.key_held, 0);
      check("midrst_press", bus.press_pulse, 0);
      check("midrst_release", bus.release_pulse, 0);
      wait_cycles(2);
      clear_counts();
      resetn = 1'b1;
      t0 = cyc;
      wait_cycles(15);
      check("postrst_cnt1", press_cnt[1], 1);
      check("postrst_time1", press_cyc[1], t0 + LAT);
      check("postrst_cnt0", press_cnt[KR], 1);
      check("postrst_held", bus.key_held, 4'b1011);
      bus.key_n = '1;
      wait_cycles(15);
      check("postrst_released", bus.key_held, 0);

      // Long hold on key 2
      clear_counts();
      bus.key_n[2] = 1'b0;
      t0 = cyc;
      wait_cycles(24);
`ifdef KEY_REPEAT_EN
      check("rpt_count", hist_n, 4);
      check("rpt_t0", hist[0], t0 + LAT);
      check("rpt_t1", hist[1], t0 + LAT + RD);
      check("rpt_t2", hist[2], t0 + LAT + RD + RP);
      check("rpt_t3", hist[3], t0 + LAT + RD + 2 * RP);
`else
      check("hold_single", press_cnt[2], 1);
      check("hold_time", press_cyc[2], t0 + LAT);
`endif
      bus.key_n[2] = 1'b1;
      wait_cycles(15);
      check("hold_release", release_cnt[2], 1);

      check("no_dual_pulse", dual_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
